// File: rtl/serial_add_sub.sv
// ---------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial adder/subtractor. Operands are latched on a start request and
//   processed one bit per clock, LSB first, through a single full-adder slice
//   and one carry flip-flop. Subtraction is A + ~B + 1: the B operand is
//   inverted at load time and the carry is preset to 1.
//
// Ports
//   clk     : clock, rising edge active
//   rst_n   : asynchronous active-low reset
//   start   : request a new operation (only honoured in IDLE)
//   sub     : 0 = A+B, 1 = A-B (sampled with start)
//   a, b    : N-bit operands (sampled with start)
//   busy    : high while the serial computation is running
//   done    : one-cycle pulse when result/cout/ovf have just been updated
//   result  : N-bit sum/difference, held until the next completion
//   cout    : carry out (for subtraction 1 = no borrow)
//   ovf     : two's-complement signed overflow
// ---------------------------------------------------------------------------
module serial_add_sub #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_opa;
  logic [N-1:0]   r_opb;
  logic [N-1:0]   r_sum;
  logic           r_carry;
  logic [CW-1:0]  r_cnt;

  logic           w_s;
  logic           w_cnext;
  logic           w_last;

  // Single full-adder slice working on the current LSBs.
  assign w_s     = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_cnext = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);
  assign w_last  = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_opa   <= a;
            r_opb   <= b ^ {N{sub}};
            r_carry <= sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
            busy    <= 1'b1;
          end
        end

        S_RUN: begin
          r_carry <= w_cnext;
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_sum   <= {w_s, r_sum[N-1:1]};
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // On the MSB step r_carry is still the carry into the MSB, so
            // signed overflow is that carry XOR the carry out of the MSB.
            result  <= {w_s, r_sum[N-1:1]};
            cout    <= w_cnext;
            ovf     <= r_carry ^ w_cnext;
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_add_sub
//   Self-checking bench for serial_add_sub (N = 4, 10 ns clock). Expected
//   results come from plain integer arithmetic on the operands.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_add_sub;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cout;
  logic         ovf;

  int n_checks;
  int n_fail;
  int cyc;

  serial_add_sub #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: integer arithmetic on the operands.
  function automatic logic [N+1:0] model(input int ia, input int ib, input bit isub);
    int ures;
    int sa;
    int sb;
    int sres;
    logic [N-1:0] r;
    logic c;
    logic o;
    sa = (ia >= (1 << (N-1))) ? ia - (1 << N) : ia;
    sb = (ib >= (1 << (N-1))) ? ib - (1 << N) : ib;
    if (isub) begin
      ures = ia - ib;
      c    = (ia >= ib);
      sres = sa - sb;
    end else begin
      ures = ia + ib;
      c    = (ures >= (1 << N));
      sres = sa + sb;
    end
    r = ures[N-1:0];
    o = (sres > (1 << (N-1)) - 1) || (sres < -(1 << (N-1)));
    return {o, c, r};
  endfunction

  // Issue one operation and wait (bounded) for done. lat = edges from the
  // accepting edge until done is seen.
  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic isub,
                        output logic [N-1:0] r, output logic c, output logic o,
                        output int lat, output bit ok);
    int k;
    @(negedge clk);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    ok  = done;
    lat = k;
    r = result; c = cout; o = ovf;
  endtask

  task automatic check_op(input string name, input logic [N-1:0] ia, input logic [N-1:0] ib,
                          input logic isub);
    logic [N-1:0] r;
    logic c, o;
    int lat;
    bit ok;
    logic [N+1:0] exp;
    exp = model(int'(ia), int'(ib), isub);
    run_op(ia, ib, isub, r, c, o, lat, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s timeout: done not seen within 20 cycles", name);
    end else if ({o, c, r} !== exp) begin
      n_fail++;
      $display("FAIL %s: got ovf=%b cout=%b result=%b, expected ovf=%b cout=%b result=%b",
               name, o, c, r, exp[N+1], exp[N], exp[N-1:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, result, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b result=%b cout=%b ovf=%b, expected all 0",
               busy, done, result, cout, ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_wrap();
    logic [N+1:0] exp;
    int done_cnt;
    int first;
    exp = model(15, 1, 1'b0);
    @(negedge clk);
    a = 4'b1111; b = 4'b0001; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    done_cnt = 0; first = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k < N) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL add_wrap busy at edge t0+%0d: got %b expected 1", k, busy);
        end
      end
      if (done) begin
        done_cnt++;
        if (first < 0) first = k;
      end
      if (k < 7) @(posedge clk);
    end
    n_checks++;
    if (first !== N || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL add_wrap done timing: first at t0+%0d count %0d, expected t0+%0d count 1",
               first, done_cnt, N);
    end
    n_checks++;
    if ({ovf, cout, result} !== exp || exp !== 6'b010000) begin
      n_fail++;
      $display("FAIL add_wrap value: got ovf=%b cout=%b result=%b expected 0 1 0000",
               ovf, cout, result);
    end
  endtask

  task automatic test_sub();
    check_op("sub_7_1", 4'b0111, 4'b0001, 1'b1);
    check_op("sub_0_1", 4'b0000, 4'b0001, 1'b1);
    check_op("sub_8_1", 4'b1000, 4'b0001, 1'b1);
  endtask

  // 0111+0001 with start pulses during RUN and DONE that must be ignored.
  task automatic test_ignore_start();
    logic [N-1:0] prev;
    logic [N+1:0] exp;
    bit seen;
    int k;
    prev = result;
    exp  = model(7, 1, 1'b0);
    @(negedge clk);
    a = 4'b0111; b = 4'b0001; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    seen = 0; k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      // new operands and start during RUN/DONE
      a = 4'b0011; b = 4'b0011; sub = 1'b1; start = 1'b1;
      if (done) begin
        seen = 1;
      end else begin
        n_checks++;
        if (result !== prev) begin
          n_fail++;
          $display("FAIL ignore_start hold: result=%b changed before done, expected %b", result, prev);
        end
        @(posedge clk);
        k++;
      end
    end
    n_checks++;
    if (!seen || {ovf, cout, result} !== exp) begin
      n_fail++;
      $display("FAIL ignore_start value: seen=%0d got ovf=%b cout=%b result=%b expected %b",
               seen, ovf, cout, result, exp);
    end
    // start is still high across the DONE->IDLE edge: must not be taken
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {ovf, cout, result} !== exp) begin
        n_fail++;
        $display("FAIL ignore_start after: busy=%b done=%b result=%b, expected idle with %b",
                 busy, done, result, exp[N-1:0]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    @(negedge clk);
    a = 4'b1010; b = 4'b0101; sub = 1'b0; start = 1'b1;
    @(posedge clk);          // accept edge
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);          // first RUN step
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, result, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b done=%b result=%b cout=%b ovf=%b, expected all 0",
               busy, done, result, cout, ovf);
    end
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b1;
    repeat (N + 3) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL reset_abort activity: got %0d busy/done cycles, expected 0", dones);
    end
    check_op("after_abort_add", 4'b1010, 4'b0101, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] ra, rb;
    logic rs;
    for (int i = 0; i < 16; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rs = 1'($urandom);
      check_op("random", ra, rb, rs);
    end
  endtask

  // All 512 combinations with start held high; done spacing must be N+2.
  task automatic test_back_to_back();
    logic [N+1:0] exp;
    int last_cyc;
    int k;
    int idx;
    bit abort;
    logic [N-1:0] ca, cb;
    logic cs;
    abort = 0;
    last_cyc = -1;
    @(negedge clk);
    {cs, ca, cb} = 9'd0;
    a = ca; b = cb; sub = cs; start = 1'b1;
    for (idx = 0; idx < 512 && !abort; idx++) begin
      k = 0;
      @(negedge clk);
      while (!done && k < 20) begin
        @(negedge clk);
        k++;
      end
      n_checks++;
      if (!done) begin
        n_fail++;
        $display("FAIL sweep timeout at index %0d", idx);
        abort = 1;
      end else begin
        exp = model(int'(ca), int'(cb), cs);
        n_checks++;
        if ({ovf, cout, result} !== exp) begin
          n_fail++;
          $display("FAIL sweep a=%b b=%b sub=%b: got ovf=%b cout=%b result=%b expected %b",
                   ca, cb, cs, ovf, cout, result, exp);
        end
        if (last_cyc >= 0) begin
          n_checks++;
          if (cyc - last_cyc !== N + 2) begin
            n_fail++;
            $display("FAIL sweep spacing at index %0d: got %0d cycles expected %0d",
                     idx, cyc - last_cyc, N + 2);
          end
        end
        last_cyc = cyc;
        if (idx < 511) begin
          {cs, ca, cb} = 9'(idx + 1);
          a = ca; b = cb; sub = cs;
        end
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_add_wrap();
    test_sub();
    test_ignore_start();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial add/subtract unit: the sequential, two-direction counterpart to the team's combinational 4-bit adders. It accepts two N-bit operands and a mode bit, then computes A+B or A−B one bit per clock, LSB first, using a single carry flip-flop. It sits beside the RCA/CLA adders as the area-minimal arithmetic option. It uses a start/busy/done handshake so a controller can issue operations back to back.

## Interface
Parameters:
- `N`, default 4: operand and result width in bits (N ≥ 2).

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a new operation; sampled only in IDLE.
- `sub`  in  1: mode select, 0 = A+B, 1 = A−B; sampled with `start`.
- `a`  in  N: operand A; sampled with `start`.
- `b`  in  N: operand B; sampled with `start`.
- `busy`  out  1: high while an operation is in RUN.
- `done`  out  1: one-cycle pulse when the result is valid.
- `result`  out  N: sum or difference, held until the next completion.
- `cout`  out  1: carry out. For subtraction, 1 = no borrow and borrow = ~cout.
- `ovf`  out  1: two's-complement signed overflow.

## Operation
- States are IDLE, RUN and DONE. Encoding is implementer's choice.
- IDLE to RUN on rising edge with `start`=1. On that edge the block latches:
  - opA ← `a`
  - opB ← `b` XOR {N{`sub`}}
  - carry ← `sub`
  - bit counter ← 0
- Each RUN cycle:
  - Compute s = opA[0] ^ opB[0] ^ carry.
  - Set carry ← majority(opA[0], opB[0], carry).
  - Shift opA and opB right by one.
  - Shift s into the MSB of the internal shift register.
  - Increment the counter.
- After the RUN cycle with counter = N−1, go to DONE. On that same edge the output registers load:
  - `result` ← final shift-register value
  - `cout` ← final carry
  - `ovf` ← carry into MSB XOR final carry. Keep a one-bit copy of the carry captured before the MSB step.
- DONE to IDLE unconditionally after one cycle.
- `start` is ignored in RUN and DONE; no queuing. Operand and mode inputs may change freely except on the accepting edge.
- `result`, `cout` and `ovf` change only on entry to DONE. Mid-operation partial bits are never visible on the outputs.
- Arithmetic is modulo 2^N. {`cout`,`result`} for add equals a+b as an (N+1)-bit value. For sub, `result` = (a−b) mod 2^N and `cout` = (a ≥ b unsigned).
- `rst_n`=0, at any time including mid-RUN:
  - State goes to IDLE.
  - `busy`, `done`, `result`, `cout`, `ovf`, carry, counter and operand registers all go to 0.
  - The aborted operation produces no `done`.

## Timing
- Reset values: all outputs 0.
- `busy` is a registered output equal to (state == RUN). `done` is a registered output equal to (state == DONE).
- Cycle timing, with `start` accepted at edge t0:
  - `busy` is high from t0 through t0+N (N cycles).
  - `done` is high for exactly one cycle, after edge t0+N.
  - The block is back in IDLE after t0+N+1.
- Latency from the accepting edge to `done` is N cycles. Throughput is one operation per N+2 cycles when `start` is held high continuously.
- A `start` in the cycle when `done`=1 is ignored. The earliest next acceptance is the following edge, in IDLE.
- Reset deassertion takes effect asynchronously. The first `start` can be accepted on the first rising edge with `rst_n`=1.

## Test plan
Use N=4 and a 10 ns clock. Check every result against a+b or a−b computed in the bench.
- Reset: hold `rst_n`=0 for 2 cycles → `busy`=`done`=0, `result`=0000, `cout`=`ovf`=0.
- Add 1111+0001 → `result`=0000, `cout`=1, `ovf`=0. `done` pulses exactly 4 cycles after the accepting edge, and only for 1 cycle.
- Subtract, three cases:
  - 0111−0001 → 0110, `cout`=1, `ovf`=0.
  - 0000−0001 → 1111, `cout`=0, `ovf`=0.
  - 1000−0001 → 0111, `cout`=1, `ovf`=1.
- Add 0111+0001 → 1000, `cout`=0, `ovf`=1. Pulse `start` with new operands mid-RUN and during DONE → both ignored, and the result is unchanged. Also check that `result` keeps its previous value until `done`.
- Drop `rst_n` at the 2nd RUN cycle of 1010+0101 → all outputs 0 immediately and no `done`. A following 1010+0101 with `sub`=0 then gives 1111, `cout`=0, `ovf`=0.
- Exhaustive sweep: all 512 (a, b, sub) combinations issued back to back with `start` held high → each `done` output matches the reference model, and the spacing between `done` pulses is N+2 = 6 cycles.
